// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM that sequences a single-cycle execute unit.
// Owns PC, IR, latched load data, retire count and the halted state; shares one memory port.
module exec_sequencer #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] ir,
  output logic [15:0] pc,
  output logic [31:0] load_data,
  input  logic        ex_reg_write_en,
  input  logic [31:0] ex_rd_value,
  input  logic        ex_mem_read_en,
  input  logic        ex_mem_write_en,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_data_out,
  input  logic        ex_branch_taken,
  input  logic [15:0] ex_branch_target,
  input  logic        ex_halt,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] retired
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 16;
  localparam logic [XLEN-1:0] NOP_IR = 32'hF000_0000;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALTED  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] load_q, load_d;
  logic [XLEN-1:0] retired_q, retired_d;

  // Only the low half of the execute unit's data address reaches the memory port.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ex_mem_addr[XLEN-1:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= NOP_IR;
      load_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      load_q    <= load_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    load_d    = load_q;
    retired_d = retired_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (ex_halt)                              state_d = S_HALTED;
        else if (ex_mem_read_en || ex_mem_write_en) state_d = S_MEM;
        else                                      state_d = S_WB;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = ex_mem_write_en;
        mem_addr  = ex_mem_addr[AW-1:0];
        mem_wdata = ex_mem_data_out;
        if (mem_ready) begin
          if (!ex_mem_write_en) load_d = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we     = ex_reg_write_en;
        pc_d      = ex_branch_taken ? ex_branch_target : AW'(pc_q + PC_STEP);
        retired_d = XLEN'(retired_q + 32'd1);
        state_d   = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase

    // Requests and strobes are quiet while reset is held, so a pending access is abandoned.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rf_we     = 1'b0;
    end
  end

  assign ir        = ir_q;
  assign pc        = pc_q;
  assign load_data = load_q;
  assign retired   = retired_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALTED);
  assign rf_waddr  = ir_q[27:24];
  assign rf_wdata  = ex_rd_value;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: a toy execute unit, register file and wait-state memory surround the DUT,
// and an instruction-level model predicts pc, writebacks, stores and per-instruction latency.
module tb_exec_sequencer;
  localparam logic [15:0] PC_RESET = 16'h0000;
  localparam logic [15:0] PC_STEP  = 16'd1;
  localparam logic [31:0] NOP_IR   = 32'hF000_0000;

  // toy ISA: 0 ADD, 1 LOAD, 2 STORE, 3 BEQ, 4 JAL, 7 HALT, others NOP
  localparam logic [3:0] OP_ADD = 4'd0, OP_LD = 4'd1, OP_ST = 4'd2, OP_BEQ = 4'd3,
                         OP_JAL = 4'd4, OP_HALT = 4'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ir, load_data, retired, rf_wdata;
  logic [15:0] pc;
  logic        ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_branch_taken, ex_halt;
  logic [31:0] ex_rd_value, ex_mem_addr, ex_mem_data_out;
  logic [15:0] ex_branch_target;
  logic        rf_we, halted;
  logic [3:0]  rf_waddr;
  logic [2:0]  state;

  logic [31:0] mem  [0:65535];
  logic [31:0] rf   [0:15];
  logic [31:0] m_rf [0:15];
  logic [15:0] m_pc;
  logic [31:0] m_ret;

  int errors = 0;
  int checks = 0;

  bit          busy;
  int          wl, acc_n, fw_cfg, mw_cfg;
  logic [15:0] h_addr;
  logic        h_we;
  logic [31:0] h_wdata;
  bit          seen_we, seen_st;
  logic [15:0] st_addr;
  logic [31:0] st_data;

  exec_sequencer #(.PC_RESET(PC_RESET), .PC_STEP(PC_STEP)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir(ir), .pc(pc), .load_data(load_data),
    .ex_reg_write_en(ex_reg_write_en), .ex_rd_value(ex_rd_value),
    .ex_mem_read_en(ex_mem_read_en), .ex_mem_write_en(ex_mem_write_en),
    .ex_mem_addr(ex_mem_addr), .ex_mem_data_out(ex_mem_data_out),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_halt(ex_halt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Execute unit and memory responder, evaluated once per cycle after the clock edge.
  task automatic drive();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [15:0] imm;
    op  = ir[31:28];
    a   = rf[ir[23:20]];
    b   = rf[ir[19:16]];
    imm = ir[15:0];
    ex_reg_write_en  = (op == OP_ADD) || (op == OP_LD) || (op == OP_JAL);
    ex_rd_value      = (op == OP_ADD) ? a + b :
                       (op == OP_LD)  ? load_data :
                       (op == OP_JAL) ? {16'h0000, pc} : 32'h0;
    ex_mem_read_en   = (op == OP_LD);
    ex_mem_write_en  = (op == OP_ST);
    ex_mem_addr      = a + {16'h0000, imm};
    ex_mem_data_out  = b;
    ex_branch_taken  = ((op == OP_BEQ) && (a == b)) || (op == OP_JAL);
    ex_branch_target = pc + imm;
    ex_halt          = (op == OP_HALT);
    #1;
    if (!mem_req) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      busy      = 1'b0;
    end else begin
      if (!busy) begin
        busy    = 1'b1;
        wl      = (acc_n == 0) ? fw_cfg : mw_cfg;
        acc_n++;
        h_addr  = mem_addr;
        h_we    = mem_we;
        h_wdata = mem_wdata;
      end else begin
        chk("hold_addr", 32'(mem_addr), 32'(h_addr));
        chk("hold_we", 32'(mem_we), 32'(h_we));
        chk("hold_wdata", mem_wdata, h_wdata);
      end
      if (wl == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem_we ? $urandom : mem[mem_addr];
        busy      = 1'b0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wl--;
      end
    end
  endtask

  task automatic tick();
    logic        w_en;
    logic [3:0]  w_a;
    logic [31:0] w_d;
    if (rf_we) seen_we = 1'b1;
    if (mem_req && mem_ready && mem_we) begin
      seen_st = 1'b1;
      st_addr = mem_addr;
      st_data = mem_wdata;
      mem[mem_addr] = mem_wdata;
    end
    w_en = rf_we;
    w_a  = rf_waddr;
    w_d  = rf_wdata;
    @(posedge clk);
    #1;
    if (w_en) rf[w_a] = w_d;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'(PC_RESET));
    chk("rst_ir", ir, NOP_IR);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    rst   = 1'b0;
    m_pc  = PC_RESET;
    m_ret = 32'h0;
  endtask

  task automatic set_reg(input logic [3:0] r, input logic [31:0] v);
    rf[r]   = v;
    m_rf[r] = v;
  endtask

  // Runs one instruction to its WB cycle; starts and ends just before a clock edge.
  task automatic run(input logic [31:0] instr, input int fw, input int mw);
    logic [3:0]  op, rd, rs1, rs2;
    logic [15:0] imm, addr, npc;
    logic [31:0] a, b, val;
    bit          is_mem, we;
    int          lat;
    op  = instr[31:28];
    rd  = instr[27:24];
    rs1 = instr[23:20];
    rs2 = instr[19:16];
    imm = instr[15:0];
    a   = m_rf[rs1];
    b   = m_rf[rs2];
    addr   = 16'(a + {16'h0000, imm});
    is_mem = (op == OP_LD) || (op == OP_ST);
    we     = (op == OP_ADD) || (op == OP_LD) || (op == OP_JAL);
    npc    = (((op == OP_BEQ) && (a == b)) || (op == OP_JAL)) ? 16'(m_pc + imm) : 16'(m_pc + 16'd1);
    lat    = 4 + fw + (is_mem ? 1 + mw : 0);
    mem[m_pc] = instr;
    case (op)
      OP_ADD:  val = a + b;
      OP_LD:   val = mem[addr];
      OP_JAL:  val = {16'h0000, m_pc};
      default: val = 32'h0;
    endcase
    fw_cfg = fw;
    mw_cfg = mw;
    acc_n  = 0;
    tick();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("retired", retired, m_ret);
    chk("state_fetch", 32'(state), 32'd0);
    seen_we = 1'b0;
    seen_st = 1'b0;
    for (int c = 2; c <= lat; c++) tick();
    chk("state_wb", 32'(state), 32'd4);
    chk("early_rf_we", 32'(seen_we), 32'd0);
    chk("rf_we", 32'(rf_we), 32'(we));
    if (we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(rd));
      chk("rf_wdata", rf_wdata, val);
      m_rf[rd] = val;
    end
    if (op == OP_LD) chk("load_data", load_data, val);
    chk("store_seen", 32'(seen_st), 32'(op == OP_ST));
    if (op == OP_ST) begin
      chk("store_addr", 32'(st_addr), 32'(addr));
      chk("store_data", st_data, b);
    end
    m_pc  = npc;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic jal_to(input logic [15:0] target, input logic [3:0] rd);
    logic [15:0] off;
    off = target - m_pc;
    run({OP_JAL, rd, 4'd0, 4'd0, off}, 0, 0);
  endtask

  initial begin
    logic [3:0]  rop, rrd, rrs1, rrs2;
    logic [31:0] x;
    int          r;
    rst = 1'b1;
    mem_ready = 1'b0; mem_rdata = '0;
    ex_reg_write_en = 1'b0; ex_rd_value = '0; ex_mem_read_en = 1'b0; ex_mem_write_en = 1'b0;
    ex_mem_addr = '0; ex_mem_data_out = '0; ex_branch_taken = 1'b0; ex_branch_target = '0;
    ex_halt = 1'b0;
    busy = 1'b0; wl = 0; acc_n = 0; fw_cfg = 0; mw_cfg = 0;
    seen_we = 1'b0; seen_st = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);

    do_reset();

    // ADD r3 = r1 + r2 at pc 0, zero-wait
    run(32'h0312_0000, 0, 0);
    // LOAD r5 = mem[r4 + 0x20], two wait states on fetch and data, upper address bits discarded
    set_reg(4'd4, 32'hABCD_0100);
    run({OP_LD, 4'd5, 4'd4, 4'd0, 16'h0020}, 2, 2);
    // STORE mem[r4 + 0x40] = r6
    run({OP_ST, 4'd0, 4'd4, 4'd6, 16'h0040}, 1, 1);
    // branches around pc 10
    jal_to(16'd10, 4'd7);
    x = $urandom;
    set_reg(4'd8, x);
    set_reg(4'd9, x);
    set_reg(4'd10, ~x);
    run({OP_BEQ, 4'd0, 4'd8, 4'd9, 16'd5}, 0, 0);
    jal_to(16'd10, 4'd7);
    run({OP_BEQ, 4'd0, 4'd8, 4'd10, 16'd5}, 0, 0);
    jal_to(16'd10, 4'd7);
    run({OP_JAL, 4'd12, 4'd0, 4'd0, 16'd5}, 0, 0);
    // pc wrap-around
    jal_to(16'hFFFF, 4'd13);
    run({4'h9, 24'h0}, 0, 0);

    // randomized instruction mix with random wait states
    for (int n = 0; n < 60; n++) begin
      r    = $urandom_range(0, 12);
      rop  = (r < 5) ? 4'(r) : 4'(r + 3);
      rrd  = 4'($urandom_range(0, 15));
      rrs1 = 4'($urandom_range(0, 15));
      rrs2 = ((rop == OP_BEQ) && ($urandom_range(0, 1) == 1)) ? rrs1 : 4'($urandom_range(0, 15));
      run({rop, rrd, rrs1, rrs2, 16'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset while a fetch is stalled, with the ready arriving in the reset cycle
    mem[m_pc] = 32'h0312_0000;
    fw_cfg = 3;
    acc_n  = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_state", 32'(state), 32'd0);
    end
    do_reset();

    // HALT at pc 4 after four ADDs
    for (int n = 0; n < 4; n++) run({OP_ADD, 4'(n + 1), 4'(n), 4'(n + 2), 16'h0}, 0, 0);
    mem[m_pc] = {OP_HALT, 28'h0};
    fw_cfg = 0;
    acc_n  = 0;
    tick();
    chk("halt_pc", 32'(pc), 32'd4);
    tick();
    tick();
    tick();
    for (int c = 0; c < 20; c++) begin
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_mem_req", 32'(mem_req), 32'd0);
      chk("halt_retired", retired, m_ret);
      chk("halt_pc", 32'(pc), 32'(m_pc));
      chk("halt_ir", ir, {OP_HALT, 28'h0});
      tick();
    end
    do_reset();

    run(32'h0312_0000, 0, 0);
    tick();
    chk("final_pc", 32'(pc), 32'(m_pc));
    chk("final_retired", retired, m_ret);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
